// File: rtl/pll_lock_sequencer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : pll_lock_sequencer_pkg                                    |
// | Purpose  : State encoding and 12 MHz timing defaults for the PLL     |
// |            lock sequencer.                                           |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package pll_lock_sequencer_pkg;

    typedef enum logic [2:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        STABILIZE = 3'd2,
        RUN       = 3'd3,
        FAIL      = 3'd4
    } pll_state_t;

    localparam int c_pll_rst_cycles_12m = 16;
    localparam int c_lock_timeout_12m   = 1200;  // 100 us at 12 MHz
    localparam int c_stable_cycles_12m  = 120;
    localparam int c_max_retries        = 7;
    localparam int c_retry_w            = 4;

    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : sync_2ff                                                  |
// | Purpose  : 1-bit two-flop synchronizer, async active-low reset to 0. |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/pll_lock_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : pll_lock_sequencer                                        |
// | Purpose  : Drives iCE40 PLL RESETB, qualifies LOCK and releases the  |
// |            system reset. Optional PLL_RETRY_LIMIT_EN adds FAIL.      |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module pll_lock_sequencer
    import pll_lock_sequencer_pkg::*;
#(
    parameter int PLL_RST_CYCLES = c_pll_rst_cycles_12m,
    parameter int LOCK_TIMEOUT   = c_lock_timeout_12m,
    parameter int STABLE_CYCLES  = c_stable_cycles_12m,
    parameter int MAX_RETRIES    = c_max_retries,
    parameter int RETRY_W        = c_retry_w
) (
    input  logic               clock_in,
    input  logic               reset_n,
    input  logic               locked,
    output logic               pll_resetb,
    output logic               sys_rst_n,
    output logic               ready,
    output logic [RETRY_W-1:0] retry_count,
    output logic               lock_lost,
    output logic               fail
);

    localparam int c_cnt_w = cnt_width(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
    localparam logic [c_cnt_w-1:0] c_rst_last    = c_cnt_w'(PLL_RST_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_timeout_last = c_cnt_w'(LOCK_TIMEOUT - 1);
    localparam logic [c_cnt_w-1:0] c_stable_last  = c_cnt_w'(STABLE_CYCLES - 1);

    if (PLL_RST_CYCLES < 1) begin : g_bad_pll_rst_cycles
        $error("PLL_RST_CYCLES must be >= 1");
    end
    if (LOCK_TIMEOUT < 1) begin : g_bad_lock_timeout
        $error("LOCK_TIMEOUT must be >= 1");
    end
    if (STABLE_CYCLES < 1) begin : g_bad_stable_cycles
        $error("STABLE_CYCLES must be >= 1");
    end
    if (MAX_RETRIES < 1) begin : g_bad_max_retries
        $error("MAX_RETRIES must be >= 1");
    end

    logic               w_locked_s;
    pll_state_t         w_next_state;
    logic               w_timeout;
    logic               w_lock_loss;

    pll_state_t         r_state;
    logic [c_cnt_w-1:0] r_count;
    logic [RETRY_W-1:0] r_retry_count;
    logic               r_lock_lost;
    logic               r_pll_resetb;
    logic               r_run;

    sync_2ff u_lock_sync (
        .clk   (clock_in),
        .rst_n (reset_n),
        .i_d   (locked),
        .o_q   (w_locked_s)
    );

    // Lock seen on the timeout cycle wins over the retry.
    always_comb begin
        w_next_state = r_state;
        w_timeout    = 1'b0;
        w_lock_loss  = 1'b0;
        case (r_state)
            RESET_PLL: begin
                if (r_count == c_rst_last) w_next_state = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (w_locked_s) begin
                    w_next_state = STABILIZE;
                end else if (r_count == c_timeout_last) begin
                    w_timeout    = 1'b1;
`ifdef PLL_RETRY_LIMIT_EN
                    w_next_state = (r_retry_count == RETRY_W'(MAX_RETRIES - 1)) ? FAIL : RESET_PLL;
`else
                    w_next_state = RESET_PLL;
`endif
                end
            end
            STABILIZE: begin
                if (!w_locked_s)                    w_next_state = WAIT_LOCK;
                else if (r_count == c_stable_last)  w_next_state = RUN;
            end
            RUN: begin
                if (!w_locked_s) begin
                    w_next_state = RESET_PLL;
                    w_lock_loss  = 1'b1;
                end
            end
            FAIL:    w_next_state = FAIL;
            default: w_next_state = RESET_PLL;
        endcase
    end

    // Outputs decode the next state so they change on the same edge as r_state.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= RESET_PLL;
            r_count       <= '0;
            r_retry_count <= '0;
            r_lock_lost   <= 1'b0;
            r_pll_resetb  <= 1'b0;
            r_run         <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_next_state != r_state) begin
                r_count <= '0;
            end else if ((r_state == RESET_PLL) || (r_state == WAIT_LOCK) ||
                         (r_state == STABILIZE)) begin
                r_count <= r_count + 1'b1;
            end
            if (w_timeout && (r_retry_count != {RETRY_W{1'b1}})) begin
                r_retry_count <= r_retry_count + 1'b1;
            end
            if (w_lock_loss) begin
                r_lock_lost <= 1'b1;
            end
            r_pll_resetb <= (w_next_state != RESET_PLL) && (w_next_state != FAIL);
            r_run        <= (w_next_state == RUN);
        end
    end

`ifdef PLL_RETRY_LIMIT_EN
    logic r_fail;

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            r_fail <= 1'b0;
        end else begin
            r_fail <= (w_next_state == FAIL);
        end
    end

    assign fail = r_fail;
`else
    assign fail = 1'b0;
`endif

    assign pll_resetb  = r_pll_resetb;
    assign sys_rst_n   = r_run;
    assign ready       = r_run;
    assign retry_count = r_retry_count;
    assign lock_lost   = r_lock_lost;

endmodule
`default_nettype wire

// File: tb/tb_pll_lock_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_pll_lock_sequencer                                     |
// | Purpose  : Self-checking bench: countdown reference model plus       |
// |            directed scenarios with literal timing expectations.      |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_pll_lock_sequencer;

    localparam int PLL_RST_CYCLES = 4;
    localparam int LOCK_TIMEOUT   = 20;
    localparam int STABLE_CYCLES  = 8;
    localparam int MAX_RETRIES    = 2;
    localparam int RETRY_W        = 4;
`ifdef PLL_RETRY_LIMIT_EN
    localparam bit c_limit_en = 1'b1;
`else
    localparam bit c_limit_en = 1'b0;
`endif

    localparam int M_PR = 0, M_WAIT = 1, M_STAB = 2, M_RUN = 3, M_FAIL = 4;
    localparam int S_PLLRB = 0, S_SYSRST = 1, S_READY = 2, S_RETRY = 3, S_LOST = 4, S_FAIL = 5;

    logic               clock_in = 1'b0;
    logic               reset_n  = 1'b0;
    logic               locked   = 1'b0;
    logic               pll_resetb;
    logic               sys_rst_n;
    logic               ready;
    logic [RETRY_W-1:0] retry_count;
    logic               lock_lost;
    logic               fail;

    int n_cmp = 0;
    int n_bad = 0;
    int n;

    always #5 clock_in = ~clock_in;

    pll_lock_sequencer #(
        .PLL_RST_CYCLES (PLL_RST_CYCLES),
        .LOCK_TIMEOUT   (LOCK_TIMEOUT),
        .STABLE_CYCLES  (STABLE_CYCLES),
        .MAX_RETRIES    (MAX_RETRIES),
        .RETRY_W        (RETRY_W)
    ) dut (
        .clock_in    (clock_in),
        .reset_n     (reset_n),
        .locked      (locked),
        .pll_resetb  (pll_resetb),
        .sys_rst_n   (sys_rst_n),
        .ready       (ready),
        .retry_count (retry_count),
        .lock_lost   (lock_lost),
        .fail        (fail)
    );

    // Reference model: each phase holds a "cycles left" budget; lock is the
    // input value seen two edges earlier.
    int m_mode  = M_PR;
    int m_left  = PLL_RST_CYCLES;
    int m_retry = 0;
    bit m_lost  = 1'b0;
    bit m_h0    = 1'b0;
    bit m_h1    = 1'b0;

    always @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            m_mode  <= M_PR;
            m_left  <= PLL_RST_CYCLES;
            m_retry <= 0;
            m_lost  <= 1'b0;
            m_h0    <= 1'b0;
            m_h1    <= 1'b0;
        end else begin
            m_h0 <= locked;
            m_h1 <= m_h0;
            case (m_mode)
                M_PR: begin
                    if (m_left == 1) begin
                        m_mode <= M_WAIT;
                        m_left <= LOCK_TIMEOUT;
                    end else m_left <= m_left - 1;
                end
                M_WAIT: begin
                    if (m_h1) begin
                        m_mode <= M_STAB;
                        m_left <= STABLE_CYCLES;
                    end else if (m_left == 1) begin
                        if (m_retry < (1 << RETRY_W) - 1) m_retry <= m_retry + 1;
                        if (c_limit_en && (m_retry == MAX_RETRIES - 1)) begin
                            m_mode <= M_FAIL;
                        end else begin
                            m_mode <= M_PR;
                            m_left <= PLL_RST_CYCLES;
                        end
                    end else m_left <= m_left - 1;
                end
                M_STAB: begin
                    if (!m_h1) begin
                        m_mode <= M_WAIT;
                        m_left <= LOCK_TIMEOUT;
                    end else if (m_left == 1) m_mode <= M_RUN;
                    else m_left <= m_left - 1;
                end
                M_RUN: begin
                    if (!m_h1) begin
                        m_mode <= M_PR;
                        m_left <= PLL_RST_CYCLES;
                        m_lost <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clock_in) begin
        chk("model_pll_resetb", {31'd0, pll_resetb}, {31'd0, (m_mode != M_PR) && (m_mode != M_FAIL)});
        chk("model_sys_rst_n",  {31'd0, sys_rst_n},  {31'd0, m_mode == M_RUN});
        chk("model_ready",      {31'd0, ready},      {31'd0, m_mode == M_RUN});
        chk("model_retry",      {28'd0, retry_count}, m_retry);
        chk("model_lock_lost",  {31'd0, lock_lost},  {31'd0, m_lost});
        chk("model_fail",       {31'd0, fail},       {31'd0, m_mode == M_FAIL});
    end

    function automatic logic [31:0] sig(input int sel);
        case (sel)
            S_PLLRB:  return {31'd0, pll_resetb};
            S_SYSRST: return {31'd0, sys_rst_n};
            S_READY:  return {31'd0, ready};
            S_RETRY:  return {28'd0, retry_count};
            S_LOST:   return {31'd0, lock_lost};
            default:  return {31'd0, fail};
        endcase
    endfunction

    // Negedges until the signal equals val; returns max if it never does.
    task automatic cycles_until(input int sel, input logic [31:0] val, input int max, output int cnt);
        cnt = 0;
        while ((sig(sel) !== val) && (cnt < max)) begin
            @(negedge clock_in);
            cnt++;
        end
    endtask

    task automatic count_low(input int sel, input int max, output int cnt);
        cnt = 0;
        while ((sig(sel) === 32'd0) && (cnt < max)) begin
            cnt++;
            @(negedge clock_in);
        end
    endtask

    task automatic wait_neg(input int k);
        for (int i = 0; i < k; i++) @(negedge clock_in);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_pll_resetb"}, {31'd0, pll_resetb}, 0);
        chk({tag, "_sys_rst_n"},  {31'd0, sys_rst_n},  0);
        chk({tag, "_ready"},      {31'd0, ready},      0);
        chk({tag, "_retry"},      {28'd0, retry_count}, 0);
        chk({tag, "_lock_lost"},  {31'd0, lock_lost},  0);
        chk({tag, "_fail"},       {31'd0, fail},       0);
    endtask

    initial begin
        wait_neg(3);
        chk_reset_values("por");

        // Nominal lock
        reset_n = 1'b1;
        count_low(S_PLLRB, 50, n);
        chk("nominal_pll_rst_len", n, 4);
        wait_neg(10 - n);
        locked = 1'b1;
        cycles_until(S_READY, 1, 100, n);
        chk("nominal_lock_to_ready", n, 11);
        chk("nominal_sys_rst_n", {31'd0, sys_rst_n}, 1);
        chk("nominal_retry", {28'd0, retry_count}, 0);

        // Lock loss in RUN, then re-lock
        wait_neg(5);
        locked = 1'b0;
        cycles_until(S_SYSRST, 0, 20, n);
        chk("loss_to_sys_rst", n, 3);
        chk("loss_ready", {31'd0, ready}, 0);
        chk("loss_lock_lost", {31'd0, lock_lost}, 1);
        count_low(S_PLLRB, 50, n);
        chk("loss_pll_rst_len", n, 4);
        locked = 1'b1;
        cycles_until(S_READY, 1, 100, n);
        chk("relock_to_ready", n, 11);
        chk("relock_lock_lost", {31'd0, lock_lost}, 1);
        chk("relock_retry", {28'd0, retry_count}, 0);

        // Timeout retries with lock held off
        wait_neg(3);
        locked = 1'b0;
        cycles_until(S_PLLRB, 0, 20, n);
        chk("drop_to_pll_rst", n, 3);
        cycles_until(S_RETRY, 1, 100, n);
        chk("timeout1_period", n, 24);
        cycles_until(S_RETRY, 2, 100, n);
        chk("timeout2_period", n, 24);
`ifdef PLL_RETRY_LIMIT_EN
        wait_neg(5);
        chk("limit_fail", {31'd0, fail}, 1);
        chk("limit_pll_resetb", {31'd0, pll_resetb}, 0);
        chk("limit_retry", {28'd0, retry_count}, 2);
        wait_neg(40);
        chk("limit_fail_held", {31'd0, fail}, 1);
        chk("limit_retry_held", {28'd0, retry_count}, 2);
`else
        cycles_until(S_RETRY, 3, 100, n);
        chk("timeout3_period", n, 24);
        chk("retry_fail_tied", {31'd0, fail}, 0);
        locked = 1'b1;
        wait_neg(8);
`endif
        chk("pre_reset_lock_lost", {31'd0, lock_lost}, 1);

        // Asynchronous reset between edges
        @(posedge clock_in);
        #2 reset_n = 1'b0;
        #1 chk_reset_values("async");
        locked = 1'b0;
        wait_neg(3);
        chk_reset_values("held");

        // Unstable lock: 5 cycles high, 3 low, then steady
        reset_n = 1'b1;
        wait_neg(8);
        locked = 1'b1;
        wait_neg(5);
        locked = 1'b0;
        wait_neg(3);
        locked = 1'b1;
        cycles_until(S_READY, 1, 100, n);
        chk("unstable_lock_to_ready", n, 11);
        chk("unstable_retry", {28'd0, retry_count}, 0);
        chk("unstable_lock_lost", {31'd0, lock_lost}, 0);
        wait_neg(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
